// File: rtl/rf_wb_arbiter_pkg.sv
// Shared widths and the write-back entry type for rf_wb_arbiter.
// Widths match the register file: 5-bit index, 32-bit data.
package rf_wb_arbiter_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] wn;
      logic [DATA_W-1:0]     d;
   } wb_ent_t;

   function automatic logic reg_nz(input logic [REG_ADDR_W-1:0] r);
      return r != '0;
   endfunction

endpackage

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// wb_fifo: synchronous DEPTH-entry queue of pending MDU write-backs.
// Push when full and pop when empty are ignored; pointers wrap mod DEPTH.
module wb_fifo
   import rf_wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  wb_ent_t                   wdata,
   input  logic                      pop,
   output wb_ent_t                   rdata,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int AW = $clog2(DEPTH);

   wb_ent_t         mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     cnt_q, cnt_d;
   logic            do_push, do_pop;

   assign full  = cnt_q == (AW+1)'(DEPTH);
   assign empty = cnt_q == '0;
   assign count = cnt_q;
   assign rdata = mem_q[rd_ptr_q];

   // Next pointers and occupancy; power-of-two depth makes wrap free.
   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end

   // Pointer and count state.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage; contents are don't-care while the slot is free.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: merges WB-stage and MDU writes into one RF write port.
// Define RF_WB_BYPASS_EN to let an MDU result skip an empty queue.
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pipe_we,
   input  logic [REG_ADDR_W-1:0] pipe_wn,
   input  logic [DATA_W-1:0]     pipe_d,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_wn,
   input  logic                  mdu_valid,
   input  logic [REG_ADDR_W-1:0] mdu_wn,
   input  logic [DATA_W-1:0]     mdu_d,
   output logic                  mdu_ready,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_wn,
   output logic [DATA_W-1:0]     rf_d,
   input  logic [REG_ADDR_W-1:0] chk_rna,
   input  logic [REG_ADDR_W-1:0] chk_rnb,
   output logic                  busy_a,
   output logic                  busy_b
);

   localparam int CW = $clog2(DEPTH) + 1;

   wb_ent_t               q_head, q_wdata;
   logic                  q_push, q_pop;
   logic                  q_full, q_empty;
   logic [CW-1:0]         q_count;
   logic                  pipe_sel, mdu_ok, byp;
   logic                  rf_we_q, rf_we_d;
   logic [REG_ADDR_W-1:0] rf_wn_q, rf_wn_d;
   logic [DATA_W-1:0]     rf_d_q, rf_d_d;
   logic [31:0]           pend_q, pend_d;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (q_push),
      .wdata (q_wdata),
      .pop   (q_pop),
      .rdata (q_head),
      .full  (q_full),
      .empty (q_empty),
      .count (q_count)
   );

   assign mdu_ready = !q_full;
   assign q_wdata   = '{wn: mdu_wn, d: mdu_d};
   assign busy_a    = reg_nz(chk_rna) && pend_q[chk_rna];
   assign busy_b    = reg_nz(chk_rnb) && pend_q[chk_rnb];
   assign rf_we     = rf_we_q;
   assign rf_wn     = rf_wn_q;
   assign rf_d      = rf_d_q;

   // Pick the write source and update outstanding-MDU bookkeeping.
   always_comb begin
      pipe_sel = pipe_we && reg_nz(pipe_wn);
      mdu_ok   = mdu_valid && !q_full && reg_nz(mdu_wn);
`ifdef RF_WB_BYPASS_EN
      byp      = mdu_ok && q_empty && !pipe_sel;
`else
      byp      = 1'b0;
`endif
      q_pop    = !pipe_sel && !q_empty;
      q_push   = mdu_ok && !byp;
      rf_we_d  = 1'b0;
      rf_wn_d  = rf_wn_q;
      rf_d_d   = rf_d_q;
      pend_d   = pend_q;
      if (pipe_sel) begin
         rf_we_d = 1'b1;
         rf_wn_d = pipe_wn;
         rf_d_d  = pipe_d;
      end else if (q_pop) begin
         rf_we_d = 1'b1;
         rf_wn_d = q_head.wn;
         rf_d_d  = q_head.d;
         pend_d[q_head.wn] = 1'b0;
      end else if (byp) begin
         rf_we_d = 1'b1;
         rf_wn_d = mdu_wn;
         rf_d_d  = mdu_d;
         pend_d[mdu_wn] = 1'b0;
      end
      if (issue_valid && reg_nz(issue_wn))
         pend_d[issue_wn] = 1'b1;
      pend_d[0] = 1'b0;
   end

   // Registered RF write port and pending scoreboard.
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we_q <= 1'b0;
         rf_wn_q <= '0;
         rf_d_q  <= '0;
         pend_q  <= '0;
      end else begin
         rf_we_q <= rf_we_d;
         rf_wn_q <= rf_wn_d;
         rf_d_q  <= rf_d_d;
         pend_q  <= pend_d;
      end
   end

   // Queue flags must agree with its occupancy.
   always_ff @(posedge clk) begin
      if (!rst)
         assert (q_full == (q_count == CW'(DEPTH)) &&
                 q_empty == (q_count == '0));
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: vector table, directed
// corner sequences and randomized traffic against a queue model.
module tb_rf_wb_arbiter;

   localparam int DEPTH = 4;
`ifdef RF_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        pipe_we;
   logic [4:0]  pipe_wn;
   logic [31:0] pipe_d;
   logic        issue_valid;
   logic [4:0]  issue_wn;
   logic        mdu_valid;
   logic [4:0]  mdu_wn;
   logic [31:0] mdu_d;
   logic        mdu_ready;
   logic        rf_we;
   logic [4:0]  rf_wn;
   logic [31:0] rf_d;
   logic [4:0]  chk_rna, chk_rnb;
   logic        busy_a, busy_b;

   always #5 clk = ~clk;

   rf_wb_arbiter #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .pipe_we     (pipe_we),
      .pipe_wn     (pipe_wn),
      .pipe_d      (pipe_d),
      .issue_valid (issue_valid),
      .issue_wn    (issue_wn),
      .mdu_valid   (mdu_valid),
      .mdu_wn      (mdu_wn),
      .mdu_d       (mdu_d),
      .mdu_ready   (mdu_ready),
      .rf_we       (rf_we),
      .rf_wn       (rf_wn),
      .rf_d        (rf_d),
      .chk_rna     (chk_rna),
      .chk_rnb     (chk_rnb),
      .busy_a      (busy_a),
      .busy_b      (busy_b)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)",
                  nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [4:0]  wn;
      logic [31:0] d;
   } ent_t;

   ent_t        mq[$];
   bit          mp[32];
   logic        exp_we;
   logic [4:0]  exp_wn;
   logic [31:0] exp_d;

   task automatic idle();
      rst = 0; pipe_we = 0; pipe_wn = 0; pipe_d = 0;
      issue_valid = 0; issue_wn = 0;
      mdu_valid = 0; mdu_wn = 0; mdu_d = 0;
   endtask

   // One clock: check pre-edge outputs, advance model, check post-edge.
   task automatic step();
      ent_t e;
      bit   ready;
      bit   took;
      #1;
      ready = mq.size() < DEPTH;
      chk("mdu_ready", {31'b0, mdu_ready}, {31'b0, ready});
      chk("busy_a", {31'b0, busy_a},
          {31'b0, (chk_rna != 0) && mp[chk_rna]});
      chk("busy_b", {31'b0, busy_b},
          {31'b0, (chk_rnb != 0) && mp[chk_rnb]});
      took   = 0;
      exp_we = 0;
      if (rst) begin
         mq.delete();
         mp = '{default: 0};
         exp_wn = 0;
         exp_d  = 0;
      end else begin
         if (pipe_we && pipe_wn != 0) begin
            exp_we = 1; exp_wn = pipe_wn; exp_d = pipe_d;
         end else if (mq.size() > 0) begin
            e = mq.pop_front();
            exp_we = 1; exp_wn = e.wn; exp_d = e.d;
            mp[e.wn] = 0;
         end else if (BYP && mdu_valid && mdu_wn != 0) begin
            took = 1;
            exp_we = 1; exp_wn = mdu_wn; exp_d = mdu_d;
            mp[mdu_wn] = 0;
         end
         if (!took && mdu_valid && ready && mdu_wn != 0) begin
            e.wn = mdu_wn; e.d = mdu_d;
            mq.push_back(e);
         end
         if (issue_valid && issue_wn != 0) mp[issue_wn] = 1;
      end
      @(posedge clk);
      #1;
      chk("rf_we", {31'b0, rf_we}, {31'b0, exp_we});
      if (exp_we || rst) begin
         chk("rf_wn", {27'b0, rf_wn}, {27'b0, exp_wn});
         chk("rf_d", rf_d, exp_d);
      end
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      step();
      rst = 0;
   endtask

   typedef struct {
      logic        we;
      logic [4:0]  wn;
      logic [31:0] d;
      logic        ewe;
      logic [4:0]  ewn;
      logic [31:0] ed;
   } vec_t;

   vec_t tv[6];

   initial begin
      tv[0] = '{1'b1, 5'd5,  32'h1234,     1'b1, 5'd5,  32'h1234};
      tv[1] = '{1'b1, 5'd0,  32'hDEAD,     1'b0, 5'd0,  32'h0};
      tv[2] = '{1'b0, 5'd7,  32'h5555,     1'b0, 5'd0,  32'h0};
      tv[3] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 32'hFFFFFFFF};
      tv[4] = '{1'b1, 5'd1,  32'h0,        1'b1, 5'd1,  32'h0};
      tv[5] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0};

      idle();
      chk_rna = 0; chk_rnb = 0;
      rst = 1;
      @(posedge clk);
      #1;
      do_reset();
      chk("rst_rf_we", {31'b0, rf_we}, 32'd0);
      chk("rst_rf_wn", {27'b0, rf_wn}, 32'd0);
      chk("rst_rf_d", rf_d, 32'd0);
      chk("rst_ready", {31'b0, mdu_ready}, 32'd1);

      // Pipe-only vectors from an empty queue.
      for (int i = 0; i < 6; i++) begin
         idle();
         pipe_we = tv[i].we; pipe_wn = tv[i].wn; pipe_d = tv[i].d;
         step();
         chk($sformatf("vec%0d_we", i), {31'b0, rf_we}, {31'b0, tv[i].ewe});
         if (tv[i].ewe) begin
            chk($sformatf("vec%0d_wn", i), {27'b0, rf_wn}, {27'b0, tv[i].ewn});
            chk($sformatf("vec%0d_d", i), rf_d, tv[i].ed);
         end
      end

      // MDU result held back by three busy pipe cycles.
      do_reset();
      pipe_we = 1; pipe_wn = 1; pipe_d = 32'h11;
      mdu_valid = 1; mdu_wn = 3; mdu_d = 32'hAA;
      step();
      mdu_valid = 0;
      step();
      step();
      pipe_we = 0;
      step();
      chk("q3_we", {31'b0, rf_we}, 32'd1);
      chk("q3_wn", {27'b0, rf_wn}, 32'd3);
      chk("q3_d", rf_d, 32'hAA);

      // Fill to DEPTH, reject a fifth, drain in order.
      do_reset();
      pipe_we = 1; pipe_wn = 2; pipe_d = 32'h22;
      for (int i = 0; i < DEPTH; i++) begin
         mdu_valid = 1; mdu_wn = 5'(10 + i); mdu_d = 32'(100 + i);
         step();
      end
      chk("full_ready", {31'b0, mdu_ready}, 32'd0);
      mdu_wn = 20; mdu_d = 32'h999;
      step();
      idle();
      for (int i = 0; i < DEPTH; i++) begin
         step();
         chk($sformatf("drain%0d_wn", i), {27'b0, rf_wn}, 32'(10 + i));
         chk($sformatf("drain%0d_d", i), rf_d, 32'(100 + i));
      end
      step();
      chk("drain_end_we", {31'b0, rf_we}, 32'd0);
      chk("drain_ready", {31'b0, mdu_ready}, 32'd1);

      // Pending scoreboard for reg 7 and the r0 exclusion.
      do_reset();
      chk_rna = 7; chk_rnb = 0;
      issue_valid = 1; issue_wn = 7;
      step();
      issue_valid = 0;
      chk("busy7_set", {31'b0, busy_a}, 32'd1);
      chk("busy_r0_b", {31'b0, busy_b}, 32'd0);
      mdu_valid = 1; mdu_wn = 7; mdu_d = 32'h77;
      step();
      mdu_valid = 0;
      step();
      chk("busy7_clr", {31'b0, busy_a}, 32'd0);
      chk_rna = 0;
      issue_valid = 1; issue_wn = 0;
      step();
      issue_valid = 0;
      chk("busy_r0_a", {31'b0, busy_a}, 32'd0);

      // MDU-to-RF latency from an idle arbiter.
      do_reset();
      mdu_valid = 1; mdu_wn = 9; mdu_d = 32'h99;
      step();
      mdu_valid = 0;
`ifdef RF_WB_BYPASS_EN
      chk("lat_we", {31'b0, rf_we}, 32'd1);
      chk("lat_wn", {27'b0, rf_wn}, 32'd9);
`else
      chk("lat_we1", {31'b0, rf_we}, 32'd0);
      step();
      chk("lat_we2", {31'b0, rf_we}, 32'd1);
      chk("lat_wn", {27'b0, rf_wn}, 32'd9);
`endif

      // Reset with entries queued and registers pending.
      do_reset();
      chk_rna = 12; chk_rnb = 13;
      pipe_we = 1; pipe_wn = 4; pipe_d = 32'h44;
      for (int i = 0; i < 3; i++) begin
         issue_valid = 1; issue_wn = 5'(12 + i);
         mdu_valid = 1; mdu_wn = 5'(12 + i); mdu_d = 32'(200 + i);
         step();
      end
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step();
         chk("post_rst_we", {31'b0, rf_we}, 32'd0);
         chk("post_rst_ready", {31'b0, mdu_ready}, 32'd1);
         chk("post_rst_busy", {30'b0, busy_a, busy_b}, 32'd0);
      end

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         rst         = $urandom_range(0, 79) == 0;
         pipe_we     = $urandom_range(0, 99) < 45;
         pipe_wn     = 5'($urandom_range(0, 31));
         pipe_d      = $urandom;
         mdu_valid   = $urandom_range(0, 99) < 45;
         mdu_wn      = 5'($urandom_range(0, 31));
         mdu_d       = $urandom;
         issue_valid = $urandom_range(0, 99) < 35;
         issue_wn    = 5'($urandom_range(0, 31));
         chk_rna     = 5'($urandom_range(0, 31));
         chk_rnb     = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 1) == 1) chk_rna = mdu_wn;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
